fpu_arbiter: RTL and testbench
==============================

// Module: fpu_arbiter
// PURPOSE
// - Shares the single fpu instance between two requesters: req0 (UART command controller) and req1 (autonomous sequencer).
// - Accepts one operation at a time, round-robin, and latches operands.
// - Issues a one-cycle add/sub strobe, waits for FPU completion, captures the result and returns it to the owner.
// - Sits between the requesters and the fpu; the fpu ports connect 1:1.
// PARAMETERS
// - W_E      7    exponent width
// - W_M      15   mantissa width; word W = 1+W_E+W_M = 23, packed {s,e,m}
// - TIMEOUT  255  max cycles in WAIT before abort (used only with FPU_ARB_TIMEOUT_EN)
// PORTS
// - clk         in   1  clock
// - reset       in   1  synchronous, active-high reset
// - reqN_valid  in   1  requester N (N=0,1) has an op pending; held until reqN_ready
// - reqN_op     in   1  0=add, 1=sub; stable while valid
// - reqN_a      in   W  operand A {s,e,m}; stable while valid
// - reqN_b      in   W  operand B {s,e,m}; stable while valid
// - reqN_ready  out  1  combinational accept strobe: high exactly in the accept cycle
// - rspN_valid  out  1  one-cycle pulse, result for requester N on rsp_data
// - rsp_data    out  W  captured result; held until next capture
// - rsp_err     out  1  qualifies rspN_valid; 1 = timeout abort (always 0 without macro)
// - fpu_add     out  1  one-cycle add strobe to fpu
// - fpu_sub     out  1  one-cycle sub strobe to fpu
// - fpu_a       out  W  latched operand A -> fpu reg1_{s,e,m}
// - fpu_b       out  W  latched operand B -> fpu reg2_{s,e,m}
// - fpu_res     in   W  fpu res_{s,e,m}
// - fpu_idle    in   1  fpu idle flag
// - busy        out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset values: state=IDLE; all strobes, rsp*, rsp_err, busy = 0; fpu_a, fpu_b, rsp_data = 0; last_grant=1 (req0 wins first).
// - Reset mid-operation aborts silently: no rsp pulse, strobes low next cycle.
// - FSM states: IDLE, ISSUE, SETTLE, WAIT, DONE.
// - IDLE: any valid -> grant.
//   - Both valid -> grant the one != last_grant.
//   - On grant: reqG_ready=1, latch a/b/op/owner, last_grant<=G, -> ISSUE.
//   - Ready is never high outside IDLE.
// - ISSUE (1 cyc): fpu_add = ~op, fpu_sub = op, for exactly this cycle -> SETTLE.
// - SETTLE (1 cyc): masks the stale idle flag the cycle after the strobe -> WAIT.
// - WAIT: stays until fpu_idle==1.
//   - On that cycle, capture rsp_data <= fpu_res -> DONE.
// - DONE (1 cyc): rsp<owner>_valid=1, rsp_err as captured -> IDLE.
//   - A new grant is possible the cycle after DONE.
// - Fixed overhead: accept -> rsp pulse = 4 + k cycles, where k = cycles fpu_idle is low in WAIT (min k=0).
// - fpu_a/fpu_b remain stable from ISSUE through DONE and hold afterwards.
// - Requester dropping valid before ready: no accept, no side effects.
// - Requester raising valid while busy: waits, no loss; round-robin order is preserved.
// - last_grant updates only on accept, so a lone requester may be granted back-to-back.
// CONFIGURATION
// - FPU_ARB_TIMEOUT_EN defined:
//   - 8-bit wait counter cleared in ISSUE, incremented in SETTLE/WAIT.
//   - Reaching TIMEOUT with fpu_idle=0 -> DONE with rsp_err=1, rsp_data unchanged.
// - FPU_ARB_TIMEOUT_EN undefined:
//   - No counter; WAIT may last forever; rsp_err tied 0.
// TESTING
// Bench uses an fpu stub: idle drops the cycle after a strobe, rises after L cycles, res = a+b (add) or a-b (sub) as raw W-bit words.
// - Single op: req0 add a=23'h000010, b=23'h000001, L=5
//   -> ready0 one cycle; fpu_add one pulse 1 cycle later; rsp0_valid pulse, rsp_data=23'h000011, err=0.
// - Sub path: req1 sub a=23'h000010, b=23'h000001
//   -> fpu_sub pulses, fpu_add stays 0; rsp1_valid, rsp_data=23'h00000F.
// - Contention: both valid from reset, 3 ops each queued
//   -> grant order 0,1,0,1,0,1; no rsp to the wrong owner; ready never high while busy.
// - Reset in WAIT: assert reset 1 cycle during an op with L=20
//   -> no rsp pulse; busy=0, fpu_a=0 next cycle; a following op completes normally.
// - Timeout (FPU_ARB_TIMEOUT_EN, TIMEOUT=10): stub never raises idle
//   -> rsp0_valid with rsp_err=1 exactly 12 cycles after the ISSUE cycle; next op accepted.
// - Without macro, L=0 (idle never drops)
//   -> rsp pulse exactly 4 cycles after accept, err=0.

Source files
------------

// File: rtl/fpu_arbiter_if.sv
// Requester, response and fpu-side signals of the fpu arbiter; the slave modport is the arbiter.
// The master modport is the environment side (requesters plus fpu).
interface fpu_arbiter_if #(
  parameter int W = 23
);
  logic         req0_valid;
  logic         req0_ready;
  logic         req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic         req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         fpu_add;
  logic         fpu_sub;
  logic [W-1:0] fpu_a;
  logic [W-1:0] fpu_b;
  logic [W-1:0] fpu_res;
  logic         fpu_idle;
  logic         busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output fpu_add, fpu_sub, fpu_a, fpu_b,
    input  fpu_res, fpu_idle,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  fpu_add, fpu_sub, fpu_a, fpu_b,
    output fpu_res, fpu_idle,
    input  busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one fpu between two requesters; accept -> rsp pulse is 4 + fpu busy cycles.
// One op in flight, ready only in IDLE; optional WAIT abort under FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int W_E = 7,
  parameter int W_M = 15
`ifdef FPU_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic           clk,
  input logic           reset,
  fpu_arbiter_if.slave  bus
);
  localparam int W = 1 + W_E + W_M;

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic         grant_vld;
  logic         grant_sel;
  logic         last_grant;
  logic         owner;
  logic         op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] data_q;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_sel = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] wait_cnt;
  logic       err_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (grant_vld) state_nxt = ISSUE;
      ISSUE:  state_nxt = SETTLE;
      // fpu_idle is still stale the cycle after the strobe.
      SETTLE: state_nxt = WAIT;
      WAIT: begin
        if (bus.fpu_idle) state_nxt = DONE;
`ifdef FPU_ARB_TIMEOUT_EN
        else if (wait_cnt >= TIMEOUT_CNT) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = grant_vld && !grant_sel;
    bus.req1_ready = grant_vld && grant_sel;
    bus.fpu_add    = (state == ISSUE) && !op_q;
    bus.fpu_sub    = (state == ISSUE) && op_q;
    bus.rsp0_valid = (state == DONE) && !owner;
    bus.rsp1_valid = (state == DONE) && owner;
    bus.busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
    end else begin
      if (grant_vld) begin
        last_grant <= grant_sel;
        owner      <= grant_sel;
        op_q       <= grant_sel ? bus.req1_op : bus.req0_op;
        a_q        <= grant_sel ? bus.req1_a  : bus.req0_a;
        b_q        <= grant_sel ? bus.req1_b  : bus.req0_b;
      end
      if (state == WAIT && bus.fpu_idle) data_q <= bus.fpu_res;
    end
  end

  assign bus.fpu_a    = a_q;
  assign bus.fpu_b    = b_q;
  assign bus.rsp_data = data_q;

`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE)                         wait_cnt <= '0;
      else if (state == SETTLE || state == WAIT)  wait_cnt <= wait_cnt + 8'd1;
      if (state == WAIT) begin
        if (bus.fpu_idle)                 err_q <= 1'b0;
        else if (wait_cnt >= TIMEOUT_CNT) err_q <= 1'b1;
      end
    end
  end
  assign bus.rsp_err = err_q && (state == DONE);
`else
  assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with an fpu stub (idle low for L cycles after a strobe, res = a +/- b).
module tb_fpu_arbiter;
  localparam int W = 23;
  typedef logic [W-1:0] word_t;
  typedef struct {
    int    r;
    logic  op;
    word_t a;
    word_t b;
    int    l;
    word_t exp_data;
    int    exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_arbiter_if #(.W(W)) bus ();

  fpu_arbiter #(
    .W_E(7),
    .W_M(15)
`ifdef FPU_ARB_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // fpu stub
  int stub_l = 0;
  int stub_cnt;
  always @(posedge clk) begin
    if (reset) begin
      bus.fpu_idle <= 1'b1;
      bus.fpu_res  <= '0;
      stub_cnt     <= 0;
    end else if (bus.fpu_add || bus.fpu_sub) begin
      bus.fpu_res <= bus.fpu_add ? bus.fpu_a + bus.fpu_b : bus.fpu_a - bus.fpu_b;
      if (stub_l > 0) begin
        bus.fpu_idle <= 1'b0;
        stub_cnt     <= stub_l;
      end else begin
        bus.fpu_idle <= 1'b1;
        stub_cnt     <= 0;
      end
    end else if (stub_cnt > 0) begin
      if (stub_cnt == 1) bus.fpu_idle <= 1'b1;
      stub_cnt <= stub_cnt - 1;
    end
  end

  int n_add = 0, n_sub = 0, n_rsp = 0, n_rdy0 = 0, n_rdy1 = 0, n_bad = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.fpu_add) n_add++;
      if (bus.fpu_sub) n_sub++;
      if (bus.rsp0_valid || bus.rsp1_valid) n_rsp++;
      if (bus.req0_ready) n_rdy0++;
      if (bus.req1_ready) n_rdy1++;
      if ((bus.req0_ready || bus.req1_ready) && bus.busy) n_bad++;
      if (bus.req0_ready && bus.req1_ready) n_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic op, input word_t a, input word_t b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic drop(input int r);
    if (r == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  // One op on requester r; lat = cycles from accept to rsp pulse, -1 when no pulse arrives.
  task automatic run_op(input int r, input logic op, input word_t a, input word_t b, input int l,
                        output int lat, output word_t data, output logic err, output int owner);
    int t_acc;
    t_acc = -1;
    lat = -1; data = '0; err = 1'b0; owner = -1;
    stub_l = l;
    drive(r, 1'b1, op, a, b);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (t_acc < 0 && (r == 0 ? bus.req0_ready : bus.req1_ready)) t_acc = c;
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        lat   = (t_acc < 0) ? -1 : c - t_acc;
        data  = bus.rsp_data;
        err   = bus.rsp_err;
        owner = bus.rsp1_valid ? 1 : 0;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      if (t_acc >= 0) drop(r);
    end
    drop(r);
  endtask

  initial begin
    vec_t  vecs[6];
    int    lat, owner, a0, s0, r0, r1, rsp0;
    word_t data, sum;
    logic  err, acc0, acc1;
    int    i0, i1;
    int    gq[$];
    int    rq[$];
    word_t eq[$];
    word_t dq[$];

    vecs[0] = '{0, 1'b0, 23'h000010, 23'h000001, 5, 23'h000011, 8};
    vecs[1] = '{1, 1'b1, 23'h000010, 23'h000001, 5, 23'h00000F, 8};
    vecs[2] = '{0, 1'b1, 23'h000005, 23'h000007, 2, 23'h7FFFFE, 5};
    vecs[3] = '{0, 1'b0, 23'h7FFFFF, 23'h000002, 0, 23'h000001, 4};
    vecs[4] = '{1, 1'b0, 23'h123456, 23'h010101, 1, 23'h133557, 4};
    vecs[5] = '{1, 1'b1, 23'h400000, 23'h000001, 3, 23'h3FFFFF, 6};

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_strobe", {bus.fpu_add, bus.fpu_sub}, 0);
    check("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err}, 0);
    check("rst_fpu_a", bus.fpu_a, 0);
    check("rst_fpu_b", bus.fpu_b, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      a0 = n_add; s0 = n_sub; r0 = n_rdy0; r1 = n_rdy1;
      run_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].l, lat, data, err, owner);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("v%0d_err", i), err, 0);
      check($sformatf("v%0d_owner", i), owner, vecs[i].r);
      check($sformatf("v%0d_add_pulses", i), n_add - a0, vecs[i].op ? 0 : 1);
      check($sformatf("v%0d_sub_pulses", i), n_sub - s0, vecs[i].op ? 1 : 0);
      check($sformatf("v%0d_ready_cycles", i),
            vecs[i].r == 0 ? n_rdy0 - r0 : n_rdy1 - r1, 1);
      check($sformatf("v%0d_other_ready", i),
            vecs[i].r == 0 ? n_rdy1 - r1 : n_rdy0 - r0, 0);
    end

    // Contention: both valid out of reset, three ops each.
    reset = 1'b1;
    stub_l = 2;
    drive(0, 1'b1, 1'b0, 23'h000100, 23'h000001);
    drive(1, 1'b1, 1'b1, 23'h000200, 23'h000002);
    @(posedge clk); #1;
    reset = 1'b0;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 300 && rq.size() < 6; c++) begin
      @(negedge clk);
      acc0 = bus.req0_ready;
      acc1 = bus.req1_ready;
      if (acc0) begin gq.push_back(0); sum = bus.req0_a + bus.req0_b; eq.push_back(sum); end
      if (acc1) begin gq.push_back(1); sum = bus.req1_a - bus.req1_b; eq.push_back(sum); end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        rq.push_back(bus.rsp1_valid ? 1 : 0);
        dq.push_back(bus.rsp_data);
      end
      @(posedge clk); #1;
      if (acc0) begin
        i0++;
        if (i0 == 3) drop(0); else bus.req0_a = 23'h000100 + 23'(i0);
      end
      if (acc1) begin
        i1++;
        if (i1 == 3) drop(1); else bus.req1_a = 23'h000200 + 23'(i1);
      end
    end
    check("cont_grants", gq.size(), 6);
    check("cont_rsps", rq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("cont_grant%0d", i), i < gq.size() ? gq[i] : 99, i % 2);
      check($sformatf("cont_owner%0d", i), i < rq.size() ? rq[i] : 99, i % 2);
      check($sformatf("cont_data%0d", i), i < dq.size() ? dq[i] : 23'h7FFFFF,
            i < eq.size() ? eq[i] : 23'h7FFFFF);
    end
    check("ready_while_busy", n_bad, 0);

    // Reset while waiting on a slow fpu.
    stub_l = 20;
    drive(0, 1'b1, 1'b0, 23'h000040, 23'h000002);
    acc0 = 1'b0;
    for (int c = 0; c < 10 && !acc0; c++) begin
      @(negedge clk);
      acc0 = bus.req0_ready;
      @(posedge clk); #1;
    end
    drop(0);
    check("rw_accepted", acc0, 1);
    repeat (4) @(posedge clk);
    #1;
    rsp0 = n_rsp;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rw_busy", bus.busy, 0);
    check("rw_fpu_a", bus.fpu_a, 0);
    check("rw_strobe", {bus.fpu_add, bus.fpu_sub}, 0);
    repeat (30) @(posedge clk);
    #1;
    check("rw_no_rsp", n_rsp - rsp0, 0);
    run_op(1, 1'b0, 23'h000030, 23'h000005, 3, lat, data, err, owner);
    check("rw_next_data", data, 23'h000035);
    check("rw_next_owner", owner, 1);
    check("rw_next_latency", lat, 6);

`ifdef FPU_ARB_TIMEOUT_EN
    run_op(0, 1'b0, 23'h000001, 23'h000001, 1000, lat, data, err, owner);
    check("to_latency", lat, 13);
    check("to_err", err, 1);
    check("to_data_held", data, 23'h000035);
    check("to_owner", owner, 0);
    run_op(0, 1'b1, 23'h000009, 23'h000004, 2, lat, data, err, owner);
    check("to_next_data", data, 23'h000005);
    check("to_next_err", err, 0);
    check("to_next_latency", lat, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
